// File: rtl/l2_refill_controller_pkg.sv
// l2_refill_controller_pkg: shared state encoding and default widths for the L2 refill controller
package l2_refill_controller_pkg;
    localparam int L2C_ADDR_W = 11;
    localparam int L2C_DATA_W = 32;
    typedef enum logic [2:0] {
        L2C_IDLE    = 3'd0,
        L2C_LOOKUP  = 3'd1,
        L2C_MEM_REQ = 3'd2,
        L2C_PROMOTE = 3'd3,
        L2C_RESPOND = 3'd4
    } l2c_state_e;
endpackage

// File: rtl/l2_refill_controller_sat_counter.sv
// l2_ctrl_sat_counter: saturating event counter with synchronous clear
module l2_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
endmodule

// File: rtl/l2_refill_controller.sv
// l2_refill_controller: one-outstanding L1 miss sequencer through L2 and memory; L2_CTRL_STATS_EN adds hit/miss counters
module l2_refill_controller
    import l2_refill_controller_pkg::*;
#(
    parameter int ADDR_W = L2C_ADDR_W,
    parameter int DATA_W = L2C_DATA_W
`ifdef L2_CTRL_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_from_mem,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] l2_address,
    output logic              l2_lookup,
    input  logic              l2_hit,
    input  logic              l2_miss,
    input  logic [DATA_W-1:0] l2_data,
    output logic              l2_promote,
    output logic [DATA_W-1:0] l2_promotion_data,
`ifdef L2_CTRL_STATS_EN
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    l2c_state_e        state, state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              from_mem_q;
    logic              lookup_hit, lookup_miss;

    assign lookup_hit  = state == L2C_LOOKUP && l2_hit;
    assign lookup_miss = state == L2C_LOOKUP && !l2_hit && l2_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= L2C_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            from_mem_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == L2C_IDLE && req_valid) addr_q <= req_addr;
            if (lookup_hit) data_q <= l2_data;
            if (state == L2C_MEM_REQ && mem_ack) data_q <= mem_rdata;
            if (lookup_hit || lookup_miss) from_mem_q <= lookup_miss;
        end
    end

    always_comb begin
        state_n           = state;
        req_ready         = state == L2C_IDLE;
        l2_lookup         = state == L2C_LOOKUP;
        mem_req           = state == L2C_MEM_REQ;
        l2_promote        = state == L2C_PROMOTE;
        resp_valid        = state == L2C_RESPOND;
        resp_data         = data_q;
        resp_from_mem     = from_mem_q;
        l2_promotion_data = data_q;
        l2_address        = addr_q;
        mem_addr          = addr_q;
        case (state)
            L2C_IDLE:    state_n = req_valid ? L2C_LOOKUP : L2C_IDLE;
            L2C_LOOKUP:  state_n = l2_hit ? L2C_RESPOND : l2_miss ? L2C_MEM_REQ : L2C_LOOKUP;
            L2C_MEM_REQ: state_n = mem_ack ? L2C_PROMOTE : L2C_MEM_REQ;
            L2C_PROMOTE: state_n = L2C_RESPOND;
            L2C_RESPOND: state_n = resp_ready ? L2C_IDLE : L2C_RESPOND;
            default:     state_n = L2C_IDLE;
        endcase
    end

`ifdef L2_CTRL_STATS_EN
    l2_ctrl_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lookup_hit),
        .cnt (hit_cnt)
    );
    l2_ctrl_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lookup_miss),
        .cnt (miss_cnt)
    );
`endif
endmodule

// File: tb/tb_l2_refill_controller.sv
// tb_l2_refill_controller: table, random and corner-case checks of l2_refill_controller
module tb_l2_refill_controller;
    localparam int AW = 11;
    localparam int DW = 32;
`ifdef L2_CTRL_STATS_EN
    localparam int CW = 2;
    logic [CW-1:0] hit_cnt, miss_cnt;
    int exp_hits, exp_misses;
`endif
    logic          clk = 1'b0, rst = 1'b1;
    logic          req_valid = 1'b0, resp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          l2_hit = 1'b0, l2_miss = 1'b0, mem_ack = 1'b0;
    logic [DW-1:0] l2_data = '0, mem_rdata = '0;
    logic          req_ready, resp_valid, resp_from_mem, l2_lookup, l2_promote, mem_req;
    logic [DW-1:0] resp_data, l2_promotion_data;
    logic [AW-1:0] l2_address, mem_addr;
    int tests = 0, fails = 0;

    typedef struct {
        bit            hit;
        bit            both;
        int            lw;
        int            mw;
        int            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;
    txn_t tbl [6];

    always #5 clk = ~clk;

    l2_refill_controller #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef L2_CTRL_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .resp_from_mem     (resp_from_mem),
        .resp_ready        (resp_ready),
        .l2_address        (l2_address),
        .l2_lookup         (l2_lookup),
        .l2_hit            (l2_hit),
        .l2_miss           (l2_miss),
        .l2_data           (l2_data),
        .l2_promote        (l2_promote),
        .l2_promotion_data (l2_promotion_data),
`ifdef L2_CTRL_STATS_EN
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt),
`endif
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef L2_CTRL_STATS_EN
    task automatic chk_stats();
        chk("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
        chk("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
    endtask
`endif

    // Cycle k counts from the accept cycle (k=0); the L2/memory responders follow the same schedule.
    task automatic run_txn(input txn_t t);
        int t_dec, t_ack, t_prom, t_resp, t_hs, lat, first_resp;
        t_dec  = 1 + t.lw;
        t_ack  = t_dec + 1 + t.mw;
        t_prom = t_ack + 1;
        lat    = t.hit ? 2 + t.lw : 3 + t.lw + (t.mw + 1);
        t_resp = lat;
        t_hs   = t_resp + t.rw;
        first_resp = -1;
        for (int k = 0; k <= t_hs; k++) begin
            if (resp_valid && first_resp < 0) first_resp = k;
            chk("req_ready", 32'(req_ready), 32'(k == 0));
            chk("l2_lookup", 32'(l2_lookup), 32'(k >= 1 && k <= t_dec));
            chk("mem_req", 32'(mem_req), 32'(!t.hit && k > t_dec && k <= t_ack));
            chk("l2_promote", 32'(l2_promote), 32'(!t.hit && k == t_prom));
            chk("resp_valid", 32'(resp_valid), 32'(k >= t_resp));
            if (k >= 1 && k < t_resp) chk("l2_address", 32'(l2_address), 32'(t.addr));
            if (!t.hit && k > t_dec && k <= t_ack) chk("mem_addr", 32'(mem_addr), 32'(t.addr));
            if (!t.hit && k == t_prom) chk("promotion_data", l2_promotion_data, t.data);
            if (k >= t_resp) begin
                chk("resp_data", resp_data, t.data);
                chk("resp_from_mem", 32'(resp_from_mem), 32'(!t.hit));
            end
            req_valid = k == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            req_addr  = k == 0 ? t.addr : AW'($urandom);
            if (k >= 1 && k < t_dec) begin
                l2_hit  = 1'b0;
                l2_miss = 1'b0;
            end else if (k == t_dec) begin
                l2_hit  = t.hit;
                l2_miss = t.hit ? t.both : 1'b1;
            end else begin
                l2_hit  = 1'($urandom_range(0, 1));
                l2_miss = 1'($urandom_range(0, 1));
            end
            l2_data    = (k == t_dec && t.hit) ? t.data : $urandom;
            mem_ack    = (!t.hit && k > t_dec && k <= t_ack) ? 1'(k == t_ack) : 1'($urandom_range(0, 1));
            mem_rdata  = (!t.hit && k == t_ack) ? t.data : $urandom;
            resp_ready = k >= t_resp ? 1'(k == t_hs) : 1'($urandom_range(0, 1));
            tick();
        end
        chk("latency", 32'(first_resp), 32'(lat));
`ifdef L2_CTRL_STATS_EN
        if (t.hit) exp_hits = exp_hits == 3 ? 3 : exp_hits + 1;
        else exp_misses = exp_misses == 3 ? 3 : exp_misses + 1;
        chk_stats();
`endif
    endtask

    initial begin
        txn_t r;
        tbl[0] = '{1'b1, 1'b0, 0, 0, 0, 11'h1A4, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b0, 0, 2, 0, 11'h7FF, 32'h12345678};
        tbl[2] = '{1'b1, 1'b0, 0, 0, 4, 11'h0AA, 32'hCAFEF00D};
        tbl[3] = '{1'b0, 1'b0, 0, 0, 0, 11'h001, 32'hA5A5A5A5};
        tbl[4] = '{1'b1, 1'b1, 2, 0, 1, 11'h3C3, 32'h0BADF00D};
        tbl[5] = '{1'b0, 1'b0, 1, 5, 2, 11'h400, 32'hFFFFFFFF};
`ifdef L2_CTRL_STATS_EN
        exp_hits = 0;
        exp_misses = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst outputs", {26'd0, resp_valid, resp_from_mem, l2_lookup, l2_promote, mem_req, 1'b0}, 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst promotion_data", l2_promotion_data, 32'd0);
        chk("rst l2_address", 32'(l2_address), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
`ifdef L2_CTRL_STATS_EN
        chk_stats();
`endif
        for (int i = 0; i < 6; i++) run_txn(tbl[i]);
        for (int i = 0; i < 40; i++) begin
            r.hit  = 1'($urandom_range(0, 1));
            r.both = 1'($urandom_range(0, 1));
            r.lw   = $urandom_range(0, 3);
            r.mw   = $urandom_range(0, 4);
            r.rw   = $urandom_range(0, 3);
            r.addr = AW'($urandom);
            r.data = $urandom;
            run_txn(r);
        end
        // Reset while waiting on memory: nothing may be promoted and a late ack must be ignored.
        req_valid = 1'b1;
        req_addr  = 11'h155;
        l2_hit    = 1'b0;
        l2_miss   = 1'b0;
        mem_ack   = 1'b0;
        tick();
        req_valid = 1'b0;
        l2_miss   = 1'b1;
        tick();
        l2_miss = 1'b0;
        chk("pre-rst mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post-rst mem_req", 32'(mem_req), 32'd0);
        chk("post-rst req_ready", 32'(req_ready), 32'd1);
        chk("post-rst l2_address", 32'(l2_address), 32'd0);
        chk("post-rst mem_addr", 32'(mem_addr), 32'd0);
`ifdef L2_CTRL_STATS_EN
        exp_hits = 0;
        exp_misses = 0;
        chk_stats();
`endif
        mem_ack   = 1'b1;
        mem_rdata = 32'h5EA1AC4B;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale ack promote", 32'(l2_promote), 32'd0);
            chk("stale ack req_ready", 32'(req_ready), 32'd1);
            chk("stale ack resp_valid", 32'(resp_valid), 32'd0);
        end
        mem_ack = 1'b0;
        run_txn(tbl[1]);
        run_txn(tbl[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
